// File: rtl/otter_mc_sequencer.sv
// otter_mc_sequencer: multicycle control-unit sequencer for the OTTER RV32 core.
// Latency: 2 cycles per instruction (FETCH, EXEC), 3 for loads (adds WB), +1 per interrupt taken.
// Backpressure: none; the FSM free-runs and advances exactly one state per CLK edge.
//
// Ports:
//   CLK, RST_N           : clock and synchronous active-low reset
//   CU_OPCODE, CU_FUNC3  : instruction-register fields used for EXEC decoding
//   INTR, CSR_MIE        : level interrupt request and global interrupt enable
//   CU_PC_WRITE .. CU_INT_TAKEN : Moore/decoded datapath enables
//   CU_RST               : datapath reset (~RST_N)
//   CU_STATE, CU_INSTRET : current state encoding and retired-instruction counter
module otter_mc_sequencer #(
  // Value CU_INSTRET takes on reset; zero in a real core.
  parameter logic [63:0] INSTRET_RESET_VAL = 64'd0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [6:0]  CU_OPCODE,
  input  logic [2:0]  CU_FUNC3,
  input  logic        INTR,
  input  logic        CSR_MIE,
  output logic        CU_PC_WRITE,
  output logic        CU_REG_WRITE,
  output logic        CU_MEM_RDEN1,
  output logic        CU_MEM_RDEN2,
  output logic        CU_MEM_WE2,
  output logic        CU_CSR_WE,
  output logic        CU_INT_TAKEN,
  output logic        CU_RST,
  output logic [1:0]  CU_STATE,
  output logic [63:0] CU_INSTRET
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_INTR  = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  state_t      boundary_state;
  state_t      dec_state;
  logic        pending;
  logic        intr_prev;
  logic        intr_edge;
  logic        is_load;
  logic        retire;
  logic [63:0] instret;

  assign is_load   = (CU_OPCODE == OPC_LOAD);
  assign intr_edge = INTR & ~intr_prev;

  // An instruction retires on the edge that leaves EXEC (non-load) or WB.
  assign retire = (state == ST_WB) || ((state == ST_EXEC) && !is_load);

  // Where to go at an instruction boundary: only a registered pending
  // request is serviced, so an edge seen this cycle waits one boundary.
  assign boundary_state = (pending && CSR_MIE) ? ST_INTR : ST_FETCH;

  always_comb begin
    next_state = ST_FETCH;
    unique case (state)
      ST_FETCH: next_state = ST_EXEC;
      ST_EXEC:  next_state = is_load ? ST_WB : boundary_state;
      ST_WB:    next_state = boundary_state;
      ST_INTR:  next_state = ST_FETCH;
      default:  next_state = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      // Any in-flight instruction is dropped and a coincident INTR edge is lost.
      state     <= ST_FETCH;
      pending   <= 1'b0;
      intr_prev <= 1'b0;
      instret   <= INSTRET_RESET_VAL;
    end else begin
      state     <= next_state;
      intr_prev <= INTR;
      // A new edge takes priority over the clear on INTR entry so that
      // a request arriving exactly as one is serviced is not lost.
      if (intr_edge) begin
        pending <= 1'b1;
      end else if (next_state == ST_INTR) begin
        pending <= 1'b0;
      end
      if (retire) begin
        instret <= instret + 64'd1;
      end
    end
  end

  // During reset the enables decode as FETCH regardless of the state register.
  assign dec_state = RST_N ? state : ST_FETCH;

  always_comb begin
    CU_PC_WRITE  = 1'b0;
    CU_REG_WRITE = 1'b0;
    CU_MEM_RDEN1 = 1'b0;
    CU_MEM_RDEN2 = 1'b0;
    CU_MEM_WE2   = 1'b0;
    CU_CSR_WE    = 1'b0;
    CU_INT_TAKEN = 1'b0;
    unique case (dec_state)
      ST_FETCH: CU_MEM_RDEN1 = 1'b1;
      ST_EXEC: begin
        unique case (CU_OPCODE)
          OPC_LOAD: CU_MEM_RDEN2 = 1'b1;
          OPC_STORE: begin
            CU_MEM_WE2  = 1'b1;
            CU_PC_WRITE = 1'b1;
          end
          OPC_BRANCH: CU_PC_WRITE = 1'b1;
          OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM: begin
            CU_REG_WRITE = 1'b1;
            CU_PC_WRITE  = 1'b1;
          end
          OPC_SYSTEM: begin
            // funct3 == 0 is mret: PC update only; otherwise a CSR access.
            CU_PC_WRITE = 1'b1;
            if (CU_FUNC3 != 3'b000) begin
              CU_REG_WRITE = 1'b1;
              CU_CSR_WE    = 1'b1;
            end
          end
          // Unknown opcodes execute as a NOP that still advances the PC.
          default: CU_PC_WRITE = 1'b1;
        endcase
      end
      ST_WB: begin
        CU_REG_WRITE = 1'b1;
        CU_PC_WRITE  = 1'b1;
      end
      ST_INTR: begin
        CU_INT_TAKEN = 1'b1;
        CU_PC_WRITE  = 1'b1;
      end
      default: CU_MEM_RDEN1 = 1'b1;
    endcase
  end

  assign CU_RST     = ~RST_N;
  assign CU_STATE   = state;
  assign CU_INSTRET = instret;

endmodule

// File: tb/tb_otter_mc_sequencer.sv
// tb_otter_mc_sequencer: directed plus randomized bench for otter_mc_sequencer.
// Two instances share all inputs; the second resets its counter to all-ones
// so counter wrap can be observed without a preload port.
module tb_otter_mc_sequencer;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [63:0] WRAP_PRE = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [6:0]  CU_OPCODE;
  logic [2:0]  CU_FUNC3;
  logic        INTR;
  logic        CSR_MIE;

  logic [1:0]  pc_w, reg_w, rden1, rden2, we2, csr_we, int_tk, rst_o;
  logic [1:0]  st [2];
  logic [63:0] ir [2];

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  otter_mc_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .CU_OPCODE(CU_OPCODE), .CU_FUNC3(CU_FUNC3),
    .INTR(INTR), .CSR_MIE(CSR_MIE),
    .CU_PC_WRITE(pc_w[0]), .CU_REG_WRITE(reg_w[0]), .CU_MEM_RDEN1(rden1[0]),
    .CU_MEM_RDEN2(rden2[0]), .CU_MEM_WE2(we2[0]), .CU_CSR_WE(csr_we[0]),
    .CU_INT_TAKEN(int_tk[0]), .CU_RST(rst_o[0]), .CU_STATE(st[0]), .CU_INSTRET(ir[0])
  );

  otter_mc_sequencer #(.INSTRET_RESET_VAL(WRAP_PRE)) dut_wrap (
    .CLK(CLK), .RST_N(RST_N), .CU_OPCODE(CU_OPCODE), .CU_FUNC3(CU_FUNC3),
    .INTR(INTR), .CSR_MIE(CSR_MIE),
    .CU_PC_WRITE(pc_w[1]), .CU_REG_WRITE(reg_w[1]), .CU_MEM_RDEN1(rden1[1]),
    .CU_MEM_RDEN2(rden2[1]), .CU_MEM_WE2(we2[1]), .CU_CSR_WE(csr_we[1]),
    .CU_INT_TAKEN(int_tk[1]), .CU_RST(rst_o[1]), .CU_STATE(st[1]), .CU_INSTRET(ir[1])
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chkb(input string name, input logic got, input logic exp);
    chk(name, 64'(got), 64'(exp));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Phase: 0 fetch, 1 execute, 2 writeback, 3 interrupt.
  int          m_ph   = 0;
  logic        m_pend = 1'b0;
  logic        m_prev = 1'b0;
  logic [63:0] m_cnt  = 64'd0;

  // Expected enables {pc_write, reg_write, rden1, rden2, we2, csr_we, int_taken}.
  function automatic logic [6:0] exp_en(int ph, logic [6:0] op, logic [2:0] f3, logic rn);
    int p;
    p = rn ? ph : 0;
    if (p == 0) return 7'b0010000;
    if (p == 2) return 7'b1100000;
    if (p == 3) return 7'b1000001;
    if (op == OP_LOAD)   return 7'b0001000;
    if (op == OP_STORE)  return 7'b1000100;
    if (op == OP_BRANCH) return 7'b1000000;
    if (op == OP_SYS)    return (f3 != 3'b000) ? 7'b1100010 : 7'b1000000;
    if (op == OP_LUI || op == OP_AUIPC || op == OP_JAL || op == OP_JALR ||
        op == OP_OP  || op == OP_OPIMM)
      return 7'b1100000;
    return 7'b1000000;
  endfunction

  always @(posedge CLK) begin : model
    int   nxt;
    logic at_boundary_irq;
    if (!RST_N) begin
      m_ph = 0; m_pend = 1'b0; m_prev = 1'b0; m_cnt = 64'd0;
    end else begin
      at_boundary_irq = m_pend && CSR_MIE;
      if (m_ph == 0)      nxt = 1;
      else if (m_ph == 3) nxt = 0;
      else if (m_ph == 1 && CU_OPCODE == OP_LOAD) nxt = 2;
      else                nxt = at_boundary_irq ? 3 : 0;
      if (m_ph == 2 || (m_ph == 1 && CU_OPCODE != OP_LOAD)) m_cnt = m_cnt + 64'd1;
      if (INTR && !m_prev) m_pend = 1'b1;
      else if (nxt == 3)   m_pend = 1'b0;
      m_prev = INTR;
      m_ph   = nxt;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("en[%0d]", i),
            64'({pc_w[i], reg_w[i], rden1[i], rden2[i], we2[i], csr_we[i], int_tk[i]}),
            64'(exp_en(m_ph, CU_OPCODE, CU_FUNC3, RST_N)));
        chkb($sformatf("cu_rst[%0d]", i), rst_o[i], !RST_N);
        chk($sformatf("state[%0d]", i), 64'(st[i]), 64'(m_ph));
        chk($sformatf("instret[%0d]", i), ir[i], (i == 1) ? m_cnt + WRAP_PRE : m_cnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [6:0] opc_tab [11] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                               OP_STORE, OP_OPIMM, OP_OP, OP_SYS, OP_SYS};

  initial begin
    RST_N = 1'b0; INTR = 1'b0; CSR_MIE = 1'b1; CU_OPCODE = OP_OP; CU_FUNC3 = 3'b000;
    tick();
    chk_en = 1'b1;
    chkb("rst_cu_rst", rst_o[0], 1'b1);
    chkb("rst_rden1", rden1[0], 1'b1);
    chkb("rst_pcw", pc_w[0], 1'b0);
    tick();
    chk("rst_state", 64'(st[0]), 64'd0);
    chk("rst_instret", ir[0], 64'd0);

    // Three OP instructions: F,E,F,E,F,E then 3 retired.
    RST_N = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("op3_state%0d", k), 64'(st[0]), 64'(k % 2));
      tick();
    end
    chk("op3_instret", ir[0], 64'd3);
    chk("op3_state_end", 64'(st[0]), 64'd0);

    // LOAD: FETCH -> EXEC (rden2) -> WB (reg write).
    CU_OPCODE = OP_LOAD; #1;
    chkb("ld_f_rden2", rden2[0], 1'b0);
    chkb("ld_f_regw", reg_w[0], 1'b0);
    tick();
    chk("ld_e_state", 64'(st[0]), 64'd1);
    chkb("ld_e_rden2", rden2[0], 1'b1);
    chkb("ld_e_regw", reg_w[0], 1'b0);
    chkb("ld_e_pcw", pc_w[0], 1'b0);
    tick();
    chk("ld_w_state", 64'(st[0]), 64'd2);
    chkb("ld_w_rden2", rden2[0], 1'b0);
    chkb("ld_w_regw", reg_w[0], 1'b1);
    chk("ld_w_instret", ir[0], 64'd3);
    tick();
    chk("ld_done_state", 64'(st[0]), 64'd0);
    chk("ld_instret", ir[0], 64'd4);

    // Interrupt pulse in FETCH with MIE=1.
    CU_OPCODE = OP_OP; INTR = 1'b1;
    tick();
    INTR = 1'b0;
    chk("irq_e_state", 64'(st[0]), 64'd1);
    tick();
    chk("irq_state", 64'(st[0]), 64'd3);
    chkb("irq_taken", int_tk[0], 1'b1);
    chkb("irq_pcw", pc_w[0], 1'b1);
    chk("irq_instret", ir[0], 64'd5);
    tick();
    chk("irq_back_state", 64'(st[0]), 64'd0);
    chkb("irq_taken_off", int_tk[0], 1'b0);

    // Interrupt held off by MIE=0 for 5 instructions.
    CSR_MIE = 1'b0; INTR = 1'b1;
    tick();
    INTR = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mie0_f%0d", k), 64'(st[0]), 64'd0);
      tick();
      chk($sformatf("mie0_e%0d", k), 64'(st[0]), 64'd1);
      tick();
    end
    chk("mie0_state", 64'(st[0]), 64'd0);
    chk("mie0_instret", ir[0], 64'd10);
    CSR_MIE = 1'b1;
    tick();
    chk("mie1_e_state", 64'(st[0]), 64'd1);
    tick();
    chk("mie1_irq_state", 64'(st[0]), 64'd3);
    chkb("mie1_taken", int_tk[0], 1'b1);
    tick();

    // SYSTEM: CSR access then mret.
    CU_OPCODE = OP_SYS; CU_FUNC3 = 3'b001;
    tick();
    chkb("csr_we", csr_we[0], 1'b1);
    chkb("csr_regw", reg_w[0], 1'b1);
    chkb("csr_pcw", pc_w[0], 1'b1);
    tick();
    CU_FUNC3 = 3'b000;
    tick();
    chk("mret_en", 64'({pc_w[0], reg_w[0], rden1[0], rden2[0], we2[0], csr_we[0], int_tk[0]}),
        64'(7'b1000000));
    tick();

    // Counter wrap on the all-ones-reset instance.
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1; CU_OPCODE = OP_OP;
    chk("wrap_pre", ir[1], WRAP_PRE);
    tick(); tick();
    chk("wrap_0", ir[1], 64'd0);
    tick(); tick();
    chk("wrap_1", ir[1], 64'd1);

    // Reset during WB aborts the load; INTR edge during reset is discarded.
    CU_OPCODE = OP_LOAD;
    tick(); tick();
    chk("wbrst_state", 64'(st[0]), 64'd2);
    RST_N = 1'b0; INTR = 1'b1; #1;
    chkb("wbrst_cu_rst", rst_o[0], 1'b1);
    chkb("wbrst_rden1", rden1[0], 1'b1);
    chkb("wbrst_regw", reg_w[0], 1'b0);
    tick();
    chk("wbrst_state_after", 64'(st[0]), 64'd0);
    chk("wbrst_instret", ir[0], 64'd0);
    RST_N = 1'b1; INTR = 1'b0; CSR_MIE = 1'b1; CU_OPCODE = OP_OP;
    tick(); tick();
    chk("rst_irq_discard", 64'(st[0]), 64'd0);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      int idx;
      idx = $urandom_range(0, 11);
      CU_OPCODE = (idx == 11) ? 7'($urandom) : opc_tab[idx];
      CU_FUNC3  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) INTR = ~INTR;
      CSR_MIE = ($urandom_range(0, 3) != 0);
      RST_N   = ($urandom_range(0, 99) != 0);
      tick();
    end

    RST_N = 1'b1;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
